// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and convert the up/down buttons into step pulses.
// Hold-to-repeat (HOLD/REPEAT timing) is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter bit ACTIVE_LOW          = 1'b1,
    parameter int DEBOUNCE_CYCLES     = 270000,
    parameter int REPEAT_DELAY_CYCLES = 13500000,
    parameter int REPEAT_RATE_CYCLES  = 2700000
) (
    input  logic clk,
    input  logic rst,
    input  logic up_raw,
    input  logic down_raw,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_level,
    output logic down_level
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: illegal cycle-count parameters");
    end

    localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              RELEASED = ACTIVE_LOW;

    // Channel 0 is up, channel 1 is down throughout.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      pressed;
    logic [1:0]      level;
    logic [1:0]      level_d;
    logic [1:0]      flip;
    logic [1:0]      pulse;
    logic [1:0]      pulse_n;
    logic [DB_W-1:0] db_cnt [2];
    logic            lock;

    assign raw = {down_raw, up_raw};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1 <= {2{RELEASED}};
            sync2 <= {2{RELEASED}};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flip[i]    = (pressed[i] != level[i]) && (db_cnt[i] == DB_LAST);
            level_d[i] = level[i] ^ flip[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            level <= level_d;
            for (int i = 0; i < 2; i++) begin
                if (pressed[i] == level[i] || flip[i]) db_cnt[i] <= '0;
                else                                   db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    // Lock covers both the edge where the second press lands and the edge where one releases.
    assign lock = (level[0] & level[1]) | (level_d[0] & level_d[1]);

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int              RP_W       = (RP_MAX < 2) ? 1 : $clog2(RP_MAX);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYCLES - 1);

    state_t          state   [2];
    state_t          state_n [2];
    logic [RP_W-1:0] rp_cnt  [2];
    logic [RP_W-1:0] rp_cnt_n[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state[i]  <= IDLE;
                rp_cnt[i] <= '0;
            end
        end else begin
            pulse <= pulse_n;
            for (int i = 0; i < 2; i++) begin
                state[i]  <= state_n[i];
                rp_cnt[i] <= rp_cnt_n[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: defaults first so no path through this block leaves a latch behind.
            state_n[i]  = state[i];
            rp_cnt_n[i] = rp_cnt[i];
            if (!level_d[i]) begin
                state_n[i]  = IDLE;
                rp_cnt_n[i] = '0;
            end else if (lock) begin
                state_n[i]  = HOLD;
                rp_cnt_n[i] = '0;
            end else begin
                unique case (state[i])
                    IDLE: begin
                        state_n[i]  = HOLD;
                        rp_cnt_n[i] = '0;
                    end
                    HOLD: begin
                        if (rp_cnt[i] == DELAY_LAST) begin
                            state_n[i]  = REPEAT;
                            rp_cnt_n[i] = '0;
                        end else begin
                            rp_cnt_n[i] = rp_cnt[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rp_cnt[i] == RATE_LAST) rp_cnt_n[i] = '0;
                        else                        rp_cnt_n[i] = rp_cnt[i] + 1'b1;
                    end
                    default: begin
                        state_n[i]  = IDLE;
                        rp_cnt_n[i] = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pulse_n[i] = 1'b0;
            if (level_d[i] && !lock) begin
                unique case (state[i])
                    IDLE:    pulse_n[i] = 1'b1;
                    HOLD:    pulse_n[i] = (rp_cnt[i] == DELAY_LAST);
                    REPEAT:  pulse_n[i] = (rp_cnt[i] == RATE_LAST);
                    default: pulse_n[i] = 1'b0;
                endcase
            end
        end
    end
`else
    typedef enum logic {IDLE, HOLD} state_t;

    state_t state  [2];
    state_t state_n[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 2'b00;
            for (int i = 0; i < 2; i++) state[i] <= IDLE;
        end else begin
            pulse <= pulse_n;
            for (int i = 0; i < 2; i++) state[i] <= state_n[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) state_n[i] = level_d[i] ? HOLD : IDLE;
    end

    // A press that lands while locked goes straight to HOLD, so it never fires later.
    always_comb begin
        for (int i = 0; i < 2; i++)
            pulse_n[i] = (state[i] == IDLE) && level_d[i] && !lock;
    end
`endif

    assign up_pulse   = pulse[0];
    assign down_pulse = pulse[1];
    assign up_level   = level[0];
    assign down_level = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, DELAY=20, RATE=8, active-low buttons.
// Expectations follow BUTTON_AUTOREPEAT_EN the same way the design does.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic up_raw;
    logic down_raw;
    logic up_pulse;
    logic down_pulse;
    logic up_level;
    logic down_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int up_q[$];
    int dn_q[$];
    bit up_level_seen;

    button_conditioner #(
        .ACTIVE_LOW         (1'b1),
        .DEBOUNCE_CYCLES    (4),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_RATE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .up_level  (up_level),
        .down_level(down_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge number of every pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (up_pulse === 1'b1)   up_q.push_back(cyc);
        if (down_pulse === 1'b1) dn_q.push_back(cyc);
        if (up_level === 1'b1)   up_level_seen = 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_pulses(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check({tag, "_edge"}, (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        up_q.delete();
        dn_q.delete();
        up_level_seen = 1'b0;
    endtask

    initial begin
        int e0;
        int r0;
        int exp_up[$];
        int exp_dn[$];

        rst      = 1'b1;
        up_raw   = 1'b1;
        down_raw = 1'b1;

        // 1. Reset
        tick(3);
        check("rst_up_pulse",   int'(up_pulse),   0);
        check("rst_down_pulse", int'(down_pulse), 0);
        check("rst_up_level",   int'(up_level),   0);
        check("rst_down_level", int'(down_level), 0);
        rst = 1'b0;
        clear_log();
        tick(50);
        check("idle_up_pulses",   up_q.size(), 0);
        check("idle_down_pulses", dn_q.size(), 0);

        // 2. Bounce rejection
        clear_log();
        for (int i = 0; i < 10; i++) begin
            up_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        up_raw = 1'b1;
        tick(10);
        check("bounce_level_seen", int'(up_level_seen), 0);
        check("bounce_pulses",     up_q.size(), 0);

        // 3. Clean press held for 60 cycles
        clear_log();
        e0     = cyc;
        up_raw = 1'b0;
        tick(5);
        check("press_level_pre", int'(up_level), 0);
        tick(1);
        check("press_level",     int'(up_level), 1);
        check("press_pulse",     int'(up_pulse), 1);
        tick(1);
        check("press_pulse_width", int'(up_pulse), 0);
        tick(53);

        // 4. Release
        up_raw = 1'b1;
        tick(5);
        check("release_level_pre", int'(up_level), 1);
        tick(1);
        check("release_level",     int'(up_level), 0);
        tick(10);
        exp_up.delete();
        exp_up.push_back(e0 + 6);
`ifdef BUTTON_AUTOREPEAT_EN
        exp_up.push_back(e0 + 26);
        exp_up.push_back(e0 + 34);
        exp_up.push_back(e0 + 42);
        exp_up.push_back(e0 + 50);
        exp_up.push_back(e0 + 58);
`endif
        check_pulses("hold_up", up_q, exp_up);

        // 5. Lockout
        clear_log();
        e0     = cyc;
        up_raw = 1'b0;
        tick(10);
        down_raw = 1'b0;
        tick(40);
        check("lock_both_up",   int'(up_level),   1);
        check("lock_both_down", int'(down_level), 1);
        up_raw = 1'b1;
        tick(6);
        check("lock_up_released", int'(up_level),   0);
        check("lock_down_held",   int'(down_level), 1);
        tick(30);
        down_raw = 1'b1;
        tick(10);
        check("lock_down_released", int'(down_level), 0);
        exp_up.delete();
        exp_up.push_back(e0 + 6);
        exp_dn.delete();
`ifdef BUTTON_AUTOREPEAT_EN
        exp_dn.push_back(e0 + 76);
        exp_dn.push_back(e0 + 84);
`endif
        check_pulses("lock_up",   up_q, exp_up);
        check_pulses("lock_down", dn_q, exp_dn);

        // 6. Reset in the middle of HOLD
        clear_log();
        e0     = cyc;
        up_raw = 1'b0;
        tick(21);
        rst = 1'b1;
        tick(1);
        check("midrst_level", int'(up_level), 0);
        check("midrst_pulse", int'(up_pulse), 0);
        rst = 1'b0;
        r0  = cyc;
        tick(5);
        check("rerun_level_pre", int'(up_level), 0);
        check("rerun_pulse_pre", int'(up_pulse), 0);
        tick(1);
        check("rerun_level", int'(up_level), 1);
        check("rerun_pulse", int'(up_pulse), 1);
        up_raw = 1'b1;
        tick(10);
        exp_up.delete();
        exp_up.push_back(e0 + 6);
        exp_up.push_back(r0 + 6);
        check_pulses("midrst_up", up_q, exp_up);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
